mips_fetch: RTL and testbench
=============================

MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock and reset, both sampled on the rising edge of clock.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0000 (sll $0,$0,0), SHALL be the id_instr value whenever id_valid=0.
REQ-004 Port clock, input, 1 bit, SHALL be the rising-edge system clock.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port imem_req, output, 1 bit, SHALL signal an instruction-memory read request.
REQ-007 Port imem_addr, output, 32 bits, SHALL carry the request word address.
REQ-008 Port imem_ack, input, 1 bit, SHALL mark the cycle in which imem_rdata is valid.
REQ-009 Port imem_rdata, input, 32 bits, SHALL carry the returned instruction.
REQ-010 Port redirect_valid, input, 1 bit, SHALL be a branch/jump redirect strobe from the execute stage.
REQ-011 Port redirect_pc, input, 32 bits, SHALL carry the redirect target.
REQ-012 Port id_ready, input, 1 bit, SHALL indicate that decode accepts id_* this cycle.
REQ-013 Ports id_valid (1 bit), id_instr (32 bits), id_pc (32 bits) and id_pc_plus4 (32 bits), all outputs, SHALL form the IF/ID output.
REQ-014 Port misalign_err, output, 1 bit, SHALL be a sticky flag for a misaligned redirect.

Function
REQ-015 The FSM SHALL have exactly three states: FETCH, HOLD and SQUASH.
REQ-016 In FETCH and SQUASH, imem_req SHALL be 1; in HOLD, imem_req SHALL be 0.
REQ-017 imem_addr SHALL be registered and SHALL stay stable from request start until its imem_ack.
REQ-018 imem_ack in the same cycle as imem_req SHALL be legal (zero-wait memory).
REQ-019 On imem_ack in FETCH with no redirect, if the output slot is free (id_valid=0 or id_ready=1), the block SHALL load id_instr=imem_rdata, id_pc=imem_addr, id_pc_plus4=imem_addr+4 and id_valid=1 at the next edge.
REQ-020 In that case the PC SHALL advance by 4 and the next request SHALL start the following cycle, sustaining 1 instruction/cycle.
REQ-021 On imem_ack in FETCH with the output slot full (id_valid=1 and id_ready=0), the data SHALL be captured in a one-entry skid buffer and the FSM SHALL go to HOLD.
REQ-022 In HOLD, when id_ready=1, the skid entry SHALL move to the output register and the FSM SHALL return to FETCH.
REQ-023 The block SHALL never drop, duplicate or reorder instructions.
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-025 Redirect SHALL have priority over everything else: id_valid and the skid buffer are cleared at the next edge and PC is set to {redirect_pc[31:2],2'b00}.
REQ-026 A redirect in FETCH with a request outstanding and no ack SHALL send the FSM to SQUASH.
REQ-027 In SQUASH, the old imem_addr SHALL be held until imem_ack, the returned data SHALL be discarded, and the FSM SHALL then go to FETCH at the redirect PC.
REQ-028 A redirect in the same cycle as imem_ack SHALL discard the data, and the next request SHALL use the redirect PC.
REQ-029 A redirect while in SQUASH SHALL update the target PC and stay in SQUASH.
REQ-030 A redirect in HOLD SHALL clear the skid buffer and go to FETCH.
REQ-031 redirect_valid with redirect_pc[1:0]!=0 SHALL set misalign_err, which SHALL remain set until reset.
REQ-032 id_valid=1 with id_ready=0 SHALL hold all id_* outputs stable.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL enter state FETCH with PC=RESET_PC, skid empty, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, misalign_err=0 and imem_addr=RESET_PC.
REQ-034 While reset=1, imem_req SHALL be 0.
REQ-035 The first cycle after reset deasserts SHALL have imem_req=1.
REQ-036 Reset mid-SQUASH or mid-HOLD SHALL abandon the outstanding transfer; the memory side SHALL also be reset.

Structure
REQ-037 Package mips_pkg SHALL hold the FSM state enum, the 32-bit word width constant and NOP_INSTR.
REQ-038 The skid/output buffer SHALL be the sub-module mips_if_skid.

Verification
REQ-039 Reset, then zero-wait memory with id_ready=1 -> id_pc = 0x0, 0x4, 0x8 ... on consecutive cycles; first id_valid=1 one cycle after the first ack.
REQ-040 id_ready=0 for 3 cycles during streaming -> exactly 2 instructions buffered, imem_req=0 in HOLD, sequence resumes with no gap or duplicate.
REQ-041 3-cycle memory, redirect to 0x0000_0100 while a request is pending -> old data dropped, id_valid=0 until the fetch of 0x100 returns, and the next imem_addr = 0x100 only after the old ack.
REQ-042 Redirect to 0x100 in the same cycle as imem_ack -> that instruction is never presented, and the next imem_addr = 0x100.
REQ-043 Redirect to 0x0000_0103 -> misalign_err=1 and stays 1, fetch proceeds at 0x100.
REQ-044 Reset asserted for one edge during SQUASH -> reset values on the next cycle, then fetch resumes at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS instruction fetch stage
package mips_pkg;

    localparam int WORD_W = 32;

    // sll $0,$0,0 -- presented on id_instr whenever the IF/ID slot is empty
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_if_skid.sv
// rtl/mips_if_skid.sv - IF/ID output register with a one-entry skid buffer
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   flush                drop the output slot and the skid entry (redirect)
//   in_valid             a fetched instruction is delivered this cycle
//   in_instr, in_pc      the delivered instruction and its address
//   id_ready             decode accepts the id_* outputs this cycle
//   id_valid, id_instr,
//   id_pc, id_pc_plus4   registered IF/ID outputs
module mips_if_skid #(
    parameter logic [mips_pkg::WORD_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [mips_pkg::WORD_W-1:0] in_instr,
    input  logic [mips_pkg::WORD_W-1:0] in_pc,
    input  logic                        id_ready,
    output logic                        id_valid,
    output logic [mips_pkg::WORD_W-1:0] id_instr,
    output logic [mips_pkg::WORD_W-1:0] id_pc,
    output logic [mips_pkg::WORD_W-1:0] id_pc_plus4
);

    import mips_pkg::*;

    logic              skid_valid;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_pc;
    logic              slot_free;

    assign slot_free = !id_valid || id_ready;

    // The skid entry is only ever filled while the output slot is stalled,
    // so it is always older than anything that can arrive afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (id_ready) begin
                id_valid    <= 1'b1;
                id_instr    <= skid_instr;
                id_pc       <= skid_pc;
                id_pc_plus4 <= skid_pc + 32'd4;
                skid_valid  <= 1'b0;
            end
        end else if (in_valid) begin
            if (slot_free) begin
                id_valid    <= 1'b1;
                id_instr    <= in_instr;
                id_pc       <= in_pc;
                id_pc_plus4 <= in_pc + 32'd4;
            end else begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
                skid_valid <= 1'b1;
            end
        end else if (id_ready) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - MIPS instruction fetch stage with redirect squash and skid buffering
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   imem_req, imem_addr          instruction memory read request and word address
//   imem_ack, imem_rdata         read completion strobe and returned instruction
//   redirect_valid, redirect_pc  branch/jump redirect from execute
//   id_ready                     decode accepts id_* this cycle
//   id_valid, id_instr, id_pc,
//   id_pc_plus4                  IF/ID outputs
//   misalign_err                 sticky flag: a redirect target was not word aligned
module mips_fetch #(
    parameter logic [mips_pkg::WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [mips_pkg::WORD_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        imem_req,
    output logic [mips_pkg::WORD_W-1:0] imem_addr,
    input  logic                        imem_ack,
    input  logic [mips_pkg::WORD_W-1:0] imem_rdata,
    input  logic                        redirect_valid,
    input  logic [mips_pkg::WORD_W-1:0] redirect_pc,
    input  logic                        id_ready,
    output logic                        id_valid,
    output logic [mips_pkg::WORD_W-1:0] id_instr,
    output logic [mips_pkg::WORD_W-1:0] id_pc,
    output logic [mips_pkg::WORD_W-1:0] id_pc_plus4,
    output logic                        misalign_err
);

    import mips_pkg::*;

    fetch_state_t      state;
    logic [WORD_W-1:0] tgt_pc;
    logic [WORD_W-1:0] redirect_tgt;
    logic              slot_free;
    logic              deliver;

    assign redirect_tgt = word_align(redirect_pc);
    assign slot_free    = !id_valid || id_ready;
    assign deliver      = (state == FETCH) && imem_ack && !redirect_valid;

    // Gated by reset directly so no request leaks out while reset is held,
    // yet the very first cycle after release already requests RESET_PC.
    assign imem_req = !reset && (state != HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            imem_addr    <= RESET_PC;
            tgt_pc       <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            imem_addr <= redirect_tgt;
                        end else begin
                            // The outstanding read must complete at its
                            // original address before the new target is issued.
                            tgt_pc <= redirect_tgt;
                            state  <= SQUASH;
                        end
                    end else if (imem_ack) begin
                        imem_addr <= imem_addr + 32'd4;
                        if (!slot_free) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        imem_addr <= redirect_tgt;
                        state     <= FETCH;
                    end else if (id_ready) begin
                        state <= FETCH;
                    end
                end
                SQUASH: begin
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? redirect_tgt : tgt_pc;
                        state     <= FETCH;
                    end else if (redirect_valid) begin
                        tgt_pc <= redirect_tgt;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    mips_if_skid #(
        .NOP_INSTR(NOP_INSTR)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .in_valid   (deliver),
        .in_instr   (imem_rdata),
        .in_pc      (imem_addr),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

endmodule

// File: tb/tb_mips_fetch.sv
// tb/tb_mips_fetch.sv - self-checking bench for mips_fetch with memory model and scoreboard
module tb_mips_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    int          hs_count = 0;
    logic [31:0] exp_pc = RESET_PC;
    bit          exp_mis = 1'b0;
    bit          last_ack = 1'b0;
    logic [31:0] last_addr = '0;

    always #5 clock = ~clock;

    mips_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .misalign_err  (misalign_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs, let the memory model answer, advance the
    // clock and then compare the DUT against the program-order scoreboard.
    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          pv, preq, pack;
        logic [31:0] ppc, pinstr, pp4, paddr;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
        imem_ack   = imem_req && (mem_cnt >= lat - 1);
        imem_rdata = imem_ack ? memval(imem_addr) : 32'hDEAD_BEEF;
        #1;
        pv = id_valid; ppc = id_pc; pinstr = id_instr; pp4 = id_pc_plus4;
        preq = imem_req; paddr = imem_addr; pack = imem_ack;
        @(posedge clock);
        #1;
        last_ack  = pack;
        last_addr = paddr;
        if (rst) begin
            mem_cnt = 0;
            exp_pc  = RESET_PC;
            exp_mis = 1'b0;
        end else begin
            if (pack) mem_cnt = 0;
            else if (preq) mem_cnt++;
            if (pv && rdy) begin
                hs_count++;
                checks++;
                if (ppc !== exp_pc || pinstr !== memval(ppc) || pp4 !== ppc + 32'd4) begin
                    errors++;
                    $display("FAIL handshake: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                             ppc, pinstr, pp4, exp_pc, memval(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (rv) begin
                exp_pc = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
                checks++;
                if (id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_flush: id_valid=%b expected 0", id_valid);
                end
            end else if (pv && !rdy) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== ppc || id_instr !== pinstr || id_pc_plus4 !== pp4) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                             id_valid, id_pc, id_instr, ppc, pinstr);
                end
            end
            if (preq && !pack) begin
                checks++;
                if (imem_addr !== paddr) begin
                    errors++;
                    $display("FAIL addr_stable: imem_addr=%h expected %h", imem_addr, paddr);
                end
            end
            checks++;
            if (misalign_err !== exp_mis) begin
                errors++;
                $display("FAIL misalign_flag: got %b expected %b", misalign_err, exp_mis);
            end
            if (!id_valid) begin
                checks++;
                if (id_instr !== NOP) begin
                    errors++;
                    $display("FAIL nop_when_idle: id_instr=%h expected %h", id_instr, NOP);
                end
            end
        end
    endtask

    task automatic test_reset();
        lat = 1;
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_id: v=%b instr=%h pc=%h pc4=%h expected 0/%h/0/0", id_valid, id_instr, id_pc, id_pc_plus4, NOP);
        end
        checks++;
        if (misalign_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_mem: mis=%b req=%b addr=%h expected 0/0/%h", misalign_err, imem_req, imem_addr, RESET_PC);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: imem_req=%b expected 1", imem_req);
        end
    endtask

    task automatic test_stream();
        lat = 1;
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 0, 1);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== RESET_PC + 32'(4 * k)) begin
                errors++;
                $display("FAIL stream[%0d]: v=%b pc=%h expected v=1 pc=%h", k, id_valid, id_pc, RESET_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        int acks;
        lat  = 1;
        acks = 0;
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0);
            if (last_ack) acks++;
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_req[%0d]: imem_req=%b expected 0", k, imem_req);
            end
        end
        checks++;
        if (acks != 1 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL buffered_count: acks during stall=%0d v=%b expected 1 ack and v=1", acks, id_valid);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            checks++;
            if (id_valid !== 1'b1) begin
                errors++;
                $display("FAIL resume_gap[%0d]: id_valid=%b expected 1", k, id_valid);
            end
        end
    endtask

    task automatic test_redirect_pending();
        logic [31:0] old;
        bit          old_acked, addr_seen, done, found;
        lat = 3;
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (imem_req && mem_cnt == 0) found = 1'b1;
            else cycle(0, 0, 0, 1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pending_setup: no fresh request seen, req=%b cnt=%0d", imem_req, mem_cnt);
        end
        old = imem_addr;
        cycle(0, 1, 32'h0000_0100, 1);
        checks++;
        if (imem_addr !== old) begin
            errors++;
            $display("FAIL squash_addr_hold: imem_addr=%h expected %h", imem_addr, old);
        end
        old_acked = 1'b0; addr_seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            cycle(0, 0, 0, 1);
            if (last_ack && last_addr == old) old_acked = 1'b1;
            if (!addr_seen && imem_addr !== old) begin
                addr_seen = 1'b1;
                checks++;
                if (imem_addr !== 32'h100 || !old_acked) begin
                    errors++;
                    $display("FAIL squash_next_addr: addr=%h old_acked=%b expected 00000100 and 1", imem_addr, old_acked);
                end
            end
            if (id_valid) begin
                done = 1'b1;
                checks++;
                if (id_pc !== 32'h100 || !addr_seen) begin
                    errors++;
                    $display("FAIL squash_first_out: pc=%h expected 00000100", id_pc);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL squash_timeout: id_valid=%b expected 1 within 30 cycles", id_valid);
        end
    endtask

    task automatic test_redirect_ack();
        lat = 1;
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_0100, 1);
        checks++;
        if (imem_addr !== 32'h100 || id_valid !== 1'b0 || !last_ack) begin
            errors++;
            $display("FAIL redirect_ack: addr=%h v=%b ack=%b expected 00000100/0/1", imem_addr, id_valid, last_ack);
        end
        cycle(0, 0, 0, 1);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_ack_next: v=%b pc=%h expected 1/00000100", id_valid, id_pc);
        end
    endtask

    task automatic test_misalign();
        lat = 1;
        cycle(0, 1, 32'h0000_0103, 1);
        checks++;
        if (misalign_err !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL misalign_set: mis=%b addr=%h expected 1/00000100", misalign_err, imem_addr);
        end
        cycle(0, 0, 0, 1);
        checks++;
        if (id_pc !== 32'h100 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL misalign_fetch: v=%b pc=%h expected 1/00000100", id_valid, id_pc);
        end
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
        checks++;
        if (misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_sticky: mis=%b expected 1", misalign_err);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        lat = 1;
        cycle(0, 1, 32'hFFFF_FFF8, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 1);
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_pc_plus4 !== e + 32'd4) begin
                errors++;
                $display("FAIL wrap[%0d]: v=%b pc=%h pc4=%h expected 1/%h/%h", k, id_valid, id_pc, id_pc_plus4, e, e + 32'd4);
            end
        end
    endtask

    task automatic test_reset_squash();
        bit done;
        lat = 3;
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
        for (int k = 0; k < 10 && !(imem_req && mem_cnt == 0); k++) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_0203, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 ||
            misalign_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_in_squash: v=%b instr=%h pc=%h mis=%b req=%b addr=%h expected reset values",
                     id_valid, id_instr, id_pc, misalign_err, imem_req, imem_addr);
        end
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle(0, 0, 0, 1);
            if (id_valid) begin
                done = 1'b1;
                checks++;
                if (id_pc !== RESET_PC) begin
                    errors++;
                    $display("FAIL resume_after_reset: pc=%h expected %h", id_pc, RESET_PC);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL resume_timeout: id_valid=%b expected 1 within 10 cycles", id_valid);
        end
    endtask

    task automatic test_random();
        int          start_hs;
        bit          rst, rv, rdy;
        logic [31:0] rpc;
        lat = $urandom_range(1, 3);
        cycle(1, 0, 0, 1);
        start_hs = hs_count;
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) lat = $urandom_range(1, 3);
            rst = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 14) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       rpc = {$urandom_range(0, 32'h3FFF), 2'b00};
                1:       rpc = $urandom;
                default: rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            cycle(rst, rv, rpc, rdy);
        end
        checks++;
        if (hs_count - start_hs < 20) begin
            errors++;
            $display("FAIL random_progress: %0d instructions delivered, expected at least 20", hs_count - start_hs);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_redirect_ack();
        test_misalign();
        test_wrap();
        test_reset_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
